vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller.
- Generates h/v timing from porch/sync parameters with programmable sync polarity.
- Issues a pixel address request ahead of the display, then delays sync/valid/colour by a configurable fetch latency so that char-ROM/framebuffer data lines up.
- Sits between the typing-game renderer (address in, `bits` out) and the VGA pins; a pixel-clock enable allows clock-divided operation.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- PIX_LAT, 1, cycles from address out to `bits` valid; legal range 0..4
- COLOR_W, 8, bits per colour channel
- CNT_W, 11, counter/address width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- pclk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  pixel-clock enable; all state advances only when en=1
- h_addr  out  CNT_W  active-area column; 0 when not active
- v_addr  out  CNT_W  active-area row; 0 when not active
- req  out  1  h_addr/v_addr address an active pixel
- line_start  out  1  one-en-cycle pulse with address x=0
- frame_start  out  1  one-en-cycle pulse with address x=0, y=0
- bits  in  3*COLOR_W  pixel colour {r,g,b}, valid PIX_LAT en-cycles after the matching req
- hsync  out  1  horizontal sync, aligned to colour
- vsync  out  1  vertical sync, aligned to colour
- valid  out  1  display enable, aligned to colour
- vga_r, vga_g, vga_b  out  COLOR_W each  colour outputs; 0 when valid=0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined likewise.
- Counters x and y are 0-based. Line order: active, front porch, sync, back porch.
- Reset (asynchronous, active-high):
  - x=0, y=0.
  - req, line_start, frame_start = 0; h_addr, v_addr = 0.
  - All pipeline stages blanked; hsync=!HS_POL, vsync=!VS_POL; valid=0; rgb=0.
- Address stage, registered, updated on each en=1 edge from the current x/y:
  - req = (x<H_ACTIVE) && (y<V_ACTIVE).
  - h_addr = req ? x : 0; v_addr = req ? y : 0.
  - line_start = (x==0); frame_start = (x==0 && y==0).
- Counter update on the same edge:
  - x==H_TOTAL-1 -> x=0, y increments.
  - x==H_TOTAL-1 and y==V_TOTAL-1 -> x=0, y=0.
  - Otherwise x increments.
- Sync decode is performed at the address stage, then delayed:
  - hs_raw active for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw active for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC; vs_raw is whole-line based and toggles at x=0.
- Delay line: {req, hs_raw, vs_raw} pass through PIX_LAT enabled stages. `bits` is sampled on the edge where the delayed req is presented.
- Output register (one more en stage):
  - valid = delayed req.
  - hsync/vsync = delayed raw value mapped to its polarity.
  - rgb = delayed req ? bits : 0.
- Total latency from address stage to pins: PIX_LAT+1 en-cycles.
- en=0: every register holds its value; pulses are not repeated or lost; there are no internal clock-domain effects.
- Reset mid-frame: immediate return to the reset state; the first en cycle after release presents address (0,0) with frame_start=1.
- PIX_LAT=0: `bits` is sampled in the same cycle req is high (combinational fetch).

Optional Feature:
- Macro: VGA_TESTPAT_EN.
- Defined:
  - Extra input test_mode (1 bit).
  - When test_mode=1, the delayed colour is replaced by 8 vertical bars, bar = column/(H_ACTIVE/8); H_ACTIVE must be a multiple of 8.
  - Bar order, each channel all-ones or zero (r,g,b): white 111, yellow 110, cyan 011, green 010, magenta 101, red 100, blue 001, black 000.
  - The column travels with the delay line; `bits` is ignored while test_mode=1.
- Undefined: no test_mode port, no bar logic.

Decomposition:
- Package vga_pkg:
  - 640x480@60 default timing constants.
  - Polarity constants.
  - Colour-bar table.
  - Function computing CNT_W from totals.
- Sub-module vga_delay_line: parametrised width/depth enabled shift register with async reset; depth 0 is a wire.

Test Plan:
- Hold reset 5 cycles, mid-frame reset -> hsync=vsync=1, valid=0, rgb=0, req=0; first en cycle after release gives frame_start=1, h_addr=0, v_addr=0.
- Defaults, en=1 constantly -> hsync low 96 cycles every 800; vsync low 2 lines (1600 cycles) every 420000; valid high 640 per line for 480 lines.
- H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V=4/1/1/1 -> line_start every 12 cycles, frame_start every 84, v_addr 0..3 then wrap.
- bits = {h_addr[7:0], v_addr[7:0], 8'hA5} modelled with PIX_LAT=2 -> vga_r equals column, vga_g equals row, exact alignment with valid.
- en toggling 1-0-0-1 pattern -> output trace identical to en=1 run with stalls removed; no extra/dropped pulses.
- VGA_TESTPAT_EN, test_mode=1, H_ACTIVE=640 -> columns 0..79 white, 80..159 yellow, ..., 560..639 black (all 0xFF/0x00 channels).

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, sync polarity and colour-bar constants
// shared by the VGA timing generator and its users.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam bit POL_NEG = 1'b0;
    localparam bit POL_POS = 1'b1;

    // {r,g,b} per bar, left to right
    localparam logic [2:0] BAR_RGB [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010,
        3'b101, 3'b100, 3'b001, 3'b000
    };

    function automatic int cnt_width(input int h_total, input int v_total);
        int m;
        m = (h_total > v_total) ? h_total : v_total;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-address request side plus the aligned VGA pin bundle.
// master = timing generator, slave = renderer/pin consumer.
interface vga_timing_gen_if #(
    parameter int CNT_W   = 11,
    parameter int COLOR_W = 8
);
    logic [CNT_W-1:0]     h_addr;
    logic [CNT_W-1:0]     v_addr;
    logic                 req;
    logic                 line_start;
    logic                 frame_start;
    logic [3*COLOR_W-1:0] bits;
    logic                 hsync;
    logic                 vsync;
    logic                 valid;
    logic [COLOR_W-1:0]   vga_r;
    logic [COLOR_W-1:0]   vga_g;
    logic [COLOR_W-1:0]   vga_b;

    modport master (
        output h_addr, v_addr, req, line_start, frame_start,
        input  bits,
        output hsync, vsync, valid, vga_r, vga_g, vga_b
    );

    modport slave (
        input  h_addr, v_addr, req, line_start, frame_start,
        output bits,
        input  hsync, vsync, valid, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: W-bit, D-deep enabled shift register with async reset;
// D=0 degenerates to a wire.
module vga_delay_line #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    if (D == 0) begin : g_wire
        logic unused_ctl;
        assign unused_ctl = &{1'b0, clk, rst, en};
        assign dout = din;
    end else begin : g_pipe
        logic [W-1:0] stage [D];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < D; i++) stage[i] <= '0;
            end else if (en) begin
                stage[0] <= din;
                for (int i = 1; i < D; i++) stage[i] <= stage[i-1];
            end
        end
        assign dout = stage[D-1];
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing with early address request and
// fetch-latency-aligned sync/valid/colour. VGA_TESTPAT_EN adds colour bars.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = POL_NEG,
    parameter bit VS_POL   = POL_NEG,
    parameter int PIX_LAT  = 1,
    parameter int COLOR_W  = 8,
    parameter int CNT_W    = 11
) (
    input  logic pclk,
    input  logic reset,
    input  logic en,
`ifdef VGA_TESTPAT_EN
    input  logic test_mode,
`endif
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] HA   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS0  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS1  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] HMAX = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] VA   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS0  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS1  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] VMAX = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] x, y;
    logic             act, hs_dec, vs_dec;
    logic [CNT_W-1:0] h_q, v_q;
    logic             req_q, ls_q, fs_q, hs_q, vs_q;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x == HMAX) begin
                x <= '0;
                y <= (y == VMAX) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign act    = (x < HA) && (y < VA);
    assign hs_dec = (x >= HS0) && (x < HS1);
    assign vs_dec = (y >= VS0) && (y < VS1);

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            req_q <= 1'b0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            h_q   <= '0;
            v_q   <= '0;
        end else if (en) begin
            req_q <= act;
            ls_q  <= (x == '0);
            fs_q  <= (x == '0) && (y == '0);
            hs_q  <= hs_dec;
            vs_q  <= vs_dec;
            h_q   <= act ? x : '0;
            v_q   <= act ? y : '0;
        end
    end

    assign bus.h_addr      = h_q;
    assign bus.v_addr      = v_q;
    assign bus.req         = req_q;
    assign bus.line_start  = ls_q;
    assign bus.frame_start = fs_q;

`ifdef VGA_TESTPAT_EN
    localparam int DW = 3 + CNT_W;
    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);
    logic [DW-1:0]    d_in, d_out;
    logic [CNT_W-1:0] d_col;
    logic [2:0]       bar;
    assign d_in  = {req_q, hs_q, vs_q, h_q};
    assign d_col = d_out[CNT_W-1:0];
    assign bar   = BAR_RGB[3'(d_col / BAR_W)];
`else
    localparam int DW = 3;
    logic [DW-1:0] d_in, d_out;
    assign d_in = {req_q, hs_q, vs_q};
`endif

    vga_delay_line #(.W(DW), .D(PIX_LAT)) u_dly (
        .clk  (pclk),
        .rst  (reset),
        .en   (en),
        .din  (d_in),
        .dout (d_out)
    );

    logic                 d_req, d_hs, d_vs;
    logic [3*COLOR_W-1:0] pix;
    assign d_req = d_out[DW-1];
    assign d_hs  = d_out[DW-2];
    assign d_vs  = d_out[DW-3];

    always_comb begin
        pix = bus.bits;
`ifdef VGA_TESTPAT_EN
        if (test_mode) begin
            pix = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
        end
`endif
    end

    // sync idles at the inverse of its active level
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            bus.valid <= 1'b0;
            bus.hsync <= ~HS_POL;
            bus.vsync <= ~VS_POL;
            {bus.vga_r, bus.vga_g, bus.vga_b} <= '0;
        end else if (en) begin
            bus.valid <= d_req;
            bus.hsync <= d_hs ? HS_POL : ~HS_POL;
            bus.vsync <= d_vs ? VS_POL : ~VS_POL;
            {bus.vga_r, bus.vga_g, bus.vga_b} <= d_req ? pix : '0;
        end
    end
endmodule
